// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy count and
// almost-full/almost-empty flags. Sticky overflow/underflow flags need SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_param #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       write_en,
   input  logic                       read_en,
   input  logic                       err_clr,
   output logic [DATA_W-1:0]          data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              wr_acc, rd_acc;

   // Flags come from the count register only, so no input reaches them combinationally.
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign data_out     = data_out_q;

   assign rd_acc = read_en & ~empty;
   assign wr_acc = write_en & (~full | rd_acc);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         data_out_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage is deliberately not reset; when full, a simultaneous read sees the old word.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   // A new error wins over a clear in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (write_en & full & ~rd_acc) ovf_d = 1'b1;
      if (read_en & empty)           unf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH=8, DATA_W=8): stimulus pushes expected read
// words into a queue, a monitor pops and compares on every accepted read.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       write_en, read_en, err_clr;
   logic [7:0] data_out;
   logic       full, empty, almost_full, almost_empty;
   logic [3:0] count;
   logic       overflow, underflow;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb [$];

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   sync_fifo_param #(.DATA_W(8), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
      .err_clr(err_clr), .data_out(data_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: an accepted read presents its word just after the edge.
   always @(posedge clk) begin
      if (!rst && read_en && !empty) begin
         #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rd_data unexpected read, actual=%0h expected=none", data_out);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (data_out !== e) begin
               errors++;
               $display("FAIL rd_data actual=%0h expected=%0h at %0t", data_out, e, $time);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; data_in = '0; write_en = 0; read_en = 0; err_clr = 0;
      tick(); tick();
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ae", almost_empty, 1);
      chk("rst_af", almost_full, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      rst = 1'b0;
      tick();

      // Fill with 0x11..0x18
      for (int i = 0; i < 8; i++) begin
         write_en = 1; data_in = 8'h11 + 8'(i);
         tick();
         chk("fill_count", count, i + 1);
         chk("fill_af", almost_full, (i + 1 >= 6));
         chk("fill_ae", almost_empty, (i + 1 <= 2));
         chk("fill_full", full, (i + 1 == 8));
      end
      // Write while full: dropped
      data_in = 8'h99;
      tick();
      write_en = 0;
      chk("ovf_count", count, 8);
      chk("ovf_flag", overflow, ERR_EN);
      err_clr = 1;
      tick();
      err_clr = 0;
      chk("ovf_clr", overflow, 0);

      // Plain drain
      for (int i = 0; i < 8; i++) sb.push_back(8'h11 + 8'(i));
      read_en = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("drain_count", count, 7 - i);
      end
      read_en = 0;
      chk("drain_empty", empty, 1);
      chk("drain_dout", data_out, 8'h18);

      // Refill, then read+write while full
      write_en = 1;
      for (int i = 0; i < 8; i++) begin
         data_in = 8'h11 + 8'(i);
         tick();
      end
      chk("refill_full", full, 1);
      sb.push_back(8'h11);
      read_en = 1; data_in = 8'hAA;
      tick();
      write_en = 0;
      chk("rw_full_count", count, 8);
      chk("rw_full_dout", data_out, 8'h11);
      for (int i = 0; i < 7; i++) sb.push_back(8'h12 + 8'(i));
      sb.push_back(8'hAA);
      repeat (8) tick();
      read_en = 0;
      chk("rw_drain_empty", empty, 1);
      chk("rw_drain_dout", data_out, 8'hAA);

      // Read+write while empty: read ignored, no bypass
      read_en = 1; write_en = 1; data_in = 8'h55;
      tick();
      read_en = 0; write_en = 0;
      chk("re_empty_dout", data_out, 8'hAA);
      chk("re_empty_count", count, 1);
      chk("unf_flag", underflow, ERR_EN);
      sb.push_back(8'h55);
      read_en = 1;
      tick();
      read_en = 0;
      chk("re_empty_read", data_out, 8'h55);
      chk("re_empty_count0", count, 0);
      err_clr = 1;
      tick();
      err_clr = 0;
      chk("unf_clr", underflow, 0);

      // Pointer wrap: prefill 3, then 20 simultaneous read/write cycles
      write_en = 1;
      for (int i = 0; i < 3; i++) begin
         data_in = 8'hC0 + 8'(i);
         tick();
      end
      read_en = 1;
      for (int i = 0; i < 20; i++) begin
         data_in = 8'hC3 + 8'(i);
         sb.push_back(8'hC0 + 8'(i));
         tick();
         chk("wrap_count", count, 3);
      end
      write_en = 0;
      for (int i = 0; i < 3; i++) sb.push_back(8'hD4 + 8'(i));
      repeat (3) tick();
      read_en = 0;
      chk("wrap_empty", empty, 1);

      // Async reset mid-cycle with count=5
      write_en = 1;
      for (int i = 0; i < 6; i++) begin
         data_in = 8'hE0 + 8'(i);
         tick();
      end
      write_en = 0;
      sb.push_back(8'hE0);
      read_en = 1;
      tick();
      read_en = 0;
      chk("pre_rst_count", count, 5);
      #3 rst = 1'b1;
      #1;
      chk("arst_count", count, 0);
      chk("arst_empty", empty, 1);
      chk("arst_dout", data_out, 0);
      chk("arst_ae", almost_empty, 1);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_count", count, 0);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
